// File: rtl/mem_arbiter.sv
// Arbiter and access sequencer sharing one single-port synchronous RAM between
// the instruction-fetch port and the load/store port.
module mem_arbiter #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_rdata,
  output logic              fetch_valid,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  state_t            state_r;
  state_t            state_s;
  logic              grant_r;
  logic              last_grant_r;
  logic              write_r;
  logic              take_s;
  logic              pick_data_s;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic              mem_wren_r;
  logic [DATA_W-1:0] fetch_rdata_r;
  logic [DATA_W-1:0] data_rdata_r;
  logic              fetch_valid_r;
  logic              data_valid_r;
  logic              busy_r;

  // Next-state and arbitration; in RESP only the other port may be granted
  always_comb begin
    state_s     = state_r;
    take_s      = 1'b0;
    pick_data_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (fetch_req || data_req) begin
          take_s      = 1'b1;
          pick_data_s = data_req && (!fetch_req || (last_grant_r == PORT_FETCH));
          state_s     = ST_ACCESS;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (write_r) begin
          state_s = ST_RESP;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_WAIT: begin
        state_s = ST_RESP;
      end
      ST_RESP: begin
        if (grant_r == PORT_DATA) begin
          if (fetch_req) begin
            take_s      = 1'b1;
            pick_data_s = 1'b0;
            state_s     = ST_ACCESS;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          if (data_req) begin
            take_s      = 1'b1;
            pick_data_s = 1'b1;
            state_s     = ST_ACCESS;
          end else begin
            state_s = ST_IDLE;
          end
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, grant bookkeeping and busy flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      grant_r      <= PORT_FETCH;
      last_grant_r <= PORT_FETCH;
      write_r      <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != ST_IDLE);
      if (take_s) begin
        grant_r      <= pick_data_s;
        last_grant_r <= pick_data_s;
        write_r      <= pick_data_s && data_we;
      end
    end
  end

  // RAM-side registers: loaded at grant, write enable lasts only for ACCESS
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      mem_wren_r  <= 1'b0;
    end else begin
      if (take_s) begin
        if (pick_data_s) begin
          mem_addr_r  <= data_addr;
          mem_wdata_r <= data_wdata;
          mem_wren_r  <= data_we;
        end else begin
          mem_addr_r <= fetch_addr;
          mem_wren_r <= 1'b0;
        end
      end else begin
        mem_wren_r <= 1'b0;
      end
    end
  end

  // Read capture into the granted port and completion pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_rdata_r <= '0;
      data_rdata_r  <= '0;
      fetch_valid_r <= 1'b0;
      data_valid_r  <= 1'b0;
    end else begin
      if (state_r == ST_WAIT) begin
        if (grant_r == PORT_DATA) begin
          data_rdata_r <= mem_q;
        end else begin
          fetch_rdata_r <= mem_q;
        end
      end
      fetch_valid_r <= (state_s == ST_RESP) && (grant_r == PORT_FETCH);
      data_valid_r  <= (state_s == ST_RESP) && (grant_r == PORT_DATA);
    end
  end

  assign mem_addr    = mem_addr_r;
  assign mem_wdata   = mem_wdata_r;
  assign mem_wren    = mem_wren_r;
  assign fetch_rdata = fetch_rdata_r;
  assign data_rdata  = data_rdata_r;
  assign fetch_valid = fetch_valid_r;
  assign data_valid  = data_valid_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 1-cycle-latency RAM and
// per-port scoreboards of expected read data and completion cycle.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        fetch_req, data_req, data_we;
  logic [10:0] fetch_addr, data_addr;
  logic [31:0] data_wdata;
  logic [31:0] fetch_rdata, data_rdata;
  logic        fetch_valid, data_valid;
  logic [10:0] mem_addr;
  logic [31:0] mem_wdata, mem_q;
  logic        mem_wren, busy;

  logic [31:0] ram [0:2047];
  logic        pl_we = 1'b0;
  logic [10:0] pl_addr;
  logic [31:0] pl_data;

  typedef struct {
    logic [31:0] rdata;
    logic        store;
    int          cyc;
  } sb_t;

  sb_t         f_q[$];
  sb_t         d_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          r;
  int          wren_cnt;
  int          vcnt;
  logic [31:0] last_f, last_d;
  logic [31:0] order_v, busy_v;
  logic [10:0] maddr1;
  logic [31:0] mwdata1;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_rdata(fetch_rdata), .fetch_valid(fetch_valid),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_valid(data_valid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
    .mem_q(mem_q), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Registered-address RAM; the preload port lets the bench seed contents
  always @(posedge clk) begin
    if (pl_we) ram[pl_addr] <= pl_data;
    else if (mem_wren) ram[mem_addr] <= mem_wdata;
    mem_q <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [10:0] a, input logic [31:0] d);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_we = 1'b0;
  endtask

  task automatic reset_vals();
    chk("rst_mem_addr",    64'(mem_addr),    64'(0));
    chk("rst_mem_wdata",   64'(mem_wdata),   64'(0));
    chk("rst_mem_wren",    64'(mem_wren),    64'(0));
    chk("rst_fetch_rdata", 64'(fetch_rdata), 64'(0));
    chk("rst_data_rdata",  64'(data_rdata),  64'(0));
    chk("rst_fetch_valid", 64'(fetch_valid), 64'(0));
    chk("rst_data_valid",  64'(data_valid),  64'(0));
    chk("rst_busy",        64'(busy),        64'(0));
  endtask

  task automatic push_f(input logic [31:0] d, input int c);
    f_q.push_back('{rdata: d, store: 1'b0, cyc: c});
  endtask

  task automatic push_d(input logic [31:0] d, input logic st, input int c);
    d_q.push_back('{rdata: d, store: st, cyc: c});
  endtask

  task automatic sb_data();
    sb_t e;
    chk("data_sb_nonempty", 64'(d_q.size() != 0), 64'(1));
    if (d_q.size() != 0) begin
      e = d_q.pop_front();
      chk("data_latency", 64'(cyc), 64'(e.cyc));
      if (e.store) begin
        chk("data_rdata_hold_store", 64'(data_rdata), 64'(last_d));
      end else begin
        chk("data_rdata", 64'(data_rdata), 64'(e.rdata));
        last_d = e.rdata;
      end
      chk("fetch_rdata_hold_on_data", 64'(fetch_rdata), 64'(last_f));
    end
  endtask

  task automatic sb_fetch();
    sb_t e;
    chk("fetch_sb_nonempty", 64'(f_q.size() != 0), 64'(1));
    if (f_q.size() != 0) begin
      e = f_q.pop_front();
      chk("fetch_latency", 64'(cyc), 64'(e.cyc));
      chk("fetch_rdata", 64'(fetch_rdata), 64'(e.rdata));
      last_f = e.rdata;
      chk("data_rdata_hold_on_fetch", 64'(data_rdata), 64'(last_d));
    end
  endtask

  // Raise requests, keep each one up until it has been served n times, and
  // record per-cycle busy, write pulses and service order along the way.
  task automatic run(input logic f_en, input logic [10:0] f_a, input int f_n,
                     input logic d_en, input logic d_w, input logic [10:0] d_a,
                     input logic [31:0] d_wd, input int d_n);
    int f_cnt = 0;
    int d_cnt = 0;
    order_v = '0; busy_v = '0; wren_cnt = 0; maddr1 = '0; mwdata1 = '0;
    fetch_req = f_en; fetch_addr = f_a;
    data_req = d_en; data_we = d_w; data_addr = d_a; data_wdata = d_wd;
    for (int k = 0; k < 60 && (fetch_req || data_req); k++) begin
      @(negedge clk);
      if (k < 32) busy_v[k] = busy;
      if (mem_wren) wren_cnt++;
      if (k == 1) begin
        maddr1 = mem_addr;
        mwdata1 = mem_wdata;
      end
      if (data_valid) begin
        d_cnt++;
        order_v = {order_v[30:0], 1'b1};
        sb_data();
      end
      if (fetch_valid) begin
        f_cnt++;
        order_v = {order_v[30:0], 1'b0};
        sb_fetch();
      end
      @(posedge clk); #1;
      data_wdata = 32'hDEADBEEF;
      if (d_cnt >= d_n) data_req = 1'b0;
      if (f_cnt >= f_n) fetch_req = 1'b0;
    end
    chk("run_timeout", 64'({fetch_req, data_req}), 64'(0));
    fetch_req = 1'b0;
    data_req = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    reset_vals();
    last_f = '0; last_d = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    fetch_req = 1'b0; data_req = 1'b0; data_we = 1'b0;
    fetch_addr = '0; data_addr = '0; data_wdata = '0;
    pl_addr = '0; pl_data = '0;
    last_f = '0; last_d = '0;
    #2 rst_n = 1'b0;
    preload(11'd0,  32'h0000A000);
    preload(11'd3,  32'hE3A00001);
    preload(11'd5,  32'h00000055);
    preload(11'd10, 32'h00000000);
    preload(11'd29, 32'h00000008);
    preload(11'd40, 32'hF0F00040);
    preload(11'd41, 32'hDDDD0041);
    #1;
    reset_vals();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Simultaneous requests straight out of reset: data first, fetch follows
    r = cyc;
    push_d(32'h8, 1'b0, r + 3);
    push_f(32'h0000A000, r + 6);
    run(1'b1, 11'd0, 1, 1'b1, 1'b0, 11'd29, 32'h0, 1);
    chk("simul_order", 64'(order_v[1:0]), 64'(2'b10));
    chk("simul_busy", 64'(busy_v[6:0]), 64'(7'b1111110));

    // Single fetch
    r = cyc;
    push_f(32'hE3A00001, r + 3);
    run(1'b1, 11'd3, 1, 1'b0, 1'b0, 11'd0, 32'h0, 0);
    chk("fetch_busy", 64'(busy_v[3:0]), 64'(4'b1110));
    chk("fetch_mem_addr", 64'(maddr1), 64'(3));

    // Store after a fetch: both rdata registers hold, one write pulse
    r = cyc;
    push_d(32'h0, 1'b1, r + 2);
    run(1'b0, 11'd0, 0, 1'b1, 1'b1, 11'd12, 32'h77, 1);
    chk("hold_wren_cycles", 64'(wren_cnt), 64'(1));
    chk("hold_ram12", 64'(ram[12]), 64'(32'h77));

    // Store 11 to addr 10, then load it back
    r = cyc;
    push_d(32'h0, 1'b1, r + 2);
    run(1'b0, 11'd0, 0, 1'b1, 1'b1, 11'd10, 32'h0000000B, 1);
    chk("store_wren_cycles", 64'(wren_cnt), 64'(1));
    chk("store_mem_addr", 64'(maddr1), 64'(10));
    chk("store_mem_wdata", 64'(mwdata1), 64'(32'hB));
    chk("store_ram10", 64'(ram[10]), 64'(11));
    r = cyc;
    push_d(32'd11, 1'b0, r + 3);
    run(1'b0, 11'd0, 0, 1'b1, 1'b0, 11'd10, 32'h0, 1);
    chk("load_wren_cycles", 64'(wren_cnt), 64'(0));
    chk("load_mem_wren_idle", 64'(mem_wren), 64'(0));

    // Fairness: both ports request continuously for six reads
    do_reset();
    r = cyc;
    for (int i = 0; i < 3; i++) begin
      push_d(32'hDDDD0041, 1'b0, r + 3 + 6 * i);
      push_f(32'hF0F00040, r + 6 + 6 * i);
    end
    run(1'b1, 11'd40, 3, 1'b1, 1'b0, 11'd41, 32'h0, 3);
    chk("fair_order", 64'(order_v[5:0]), 64'(6'b101010));
    chk("fair_busy", 64'(busy_v[18:0]), 64'(19'h7FFFE));

    // Reset in the middle of a store to addr 5
    fetch_req = 1'b0;
    data_req = 1'b1; data_we = 1'b1; data_addr = 11'd5; data_wdata = 32'h99;
    @(negedge clk);
    @(negedge clk);
    chk("abort_wren_before", 64'(mem_wren), 64'(1));
    chk("abort_addr_before", 64'(mem_addr), 64'(5));
    #1;
    rst_n = 1'b0;
    data_req = 1'b0;
    #1;
    reset_vals();
    last_f = '0; last_d = '0;
    vcnt = 0;
    repeat (2) begin
      @(negedge clk);
      if (data_valid || fetch_valid || mem_wren) vcnt++;
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (data_valid || fetch_valid || mem_wren || busy) vcnt++;
    end
    chk("abort_no_activity", 64'(vcnt), 64'(0));
    chk("abort_ram5", 64'(ram[5]), 64'(32'h55));

    // Restart from IDLE after the aborted access
    @(posedge clk); #1;
    r = cyc;
    push_d(32'h55, 1'b0, r + 3);
    run(1'b0, 11'd0, 0, 1'b1, 1'b0, 11'd5, 32'h0, 1);

    chk("fetch_sb_drained", 64'(f_q.size()), 64'(0));
    chk("data_sb_drained", 64'(d_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
